pio_irq_service_master: RTL

//  Avalon-MM initiator that services one edge-capture PIO (1-bit input, IRQ regs at addr 2/3).

---
 rtl/pio_irq_service_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pio_irq_service_master.sv
// Avalon-MM initiator that arms an edge-capture PIO, then services its irq:
// read capture, clear capture, read pin level, hand the event off, debounce holdoff.
module pio_irq_service_master #(
  parameter logic [31:0] MASK_VALUE     = 32'h1,
  parameter int          HOLDOFF_CYCLES = 1000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pio_irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             event_valid,
  input  logic             event_ready,
  output logic             event_level,
  output logic [CNT_W-1:0] event_count,
  output logic             spurious,
  output logic             busy
);

  // A zero holdoff still needs a legal 1-bit counter declaration.
  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

  typedef enum logic [3:0] {
    INIT     = 4'd0,
    WAIT_IRQ = 4'd1,
    RD_CAP   = 4'd2,
    CAP_WAIT = 4'd3,
    WR_CLR   = 4'd4,
    RD_DAT   = 4'd5,
    DAT_WAIT = 4'd6,
    PUSH     = 4'd7,
    HOLDOFF  = 4'd8
  } state_t;

  state_t        state_r;
  logic [HW-1:0] hold_cnt_r;
  logic          unused_rdata_s;

  assign unused_rdata_s = ^avm_readdata[31:1];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : (v + CNT_W'(1'b1));
  endfunction

  // Sequencer; every output is registered from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= INIT;
      hold_cnt_r     <= {HW{1'b0}};
      avm_address    <= 2'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 32'h0;
      event_valid    <= 1'b0;
      event_level    <= 1'b0;
      event_count    <= {CNT_W{1'b0}};
      spurious       <= 1'b0;
      busy           <= 1'b1;
    end else begin
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      spurious       <= 1'b0;
      case (state_r)
        INIT: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 2'd2;
          avm_writedata  <= MASK_VALUE;
          busy           <= 1'b1;
          state_r        <= WAIT_IRQ;
        end
        WAIT_IRQ: begin
          if (enable && pio_irq) begin
            avm_chipselect <= 1'b1;
            avm_address    <= 2'd3;
            busy           <= 1'b1;
            state_r        <= RD_CAP;
          end else begin
            busy <= 1'b0;
          end
        end
        RD_CAP: begin
          state_r <= CAP_WAIT;
        end
        CAP_WAIT: begin
          if (avm_readdata[0]) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= 2'd3;
            avm_writedata  <= 32'h0;
            state_r        <= WR_CLR;
          end else begin
            // irq without a captured edge: report it and skip the clear/event.
            spurious <= 1'b1;
            busy     <= 1'b0;
            state_r  <= WAIT_IRQ;
          end
        end
        WR_CLR: begin
          avm_chipselect <= 1'b1;
          avm_address    <= 2'd0;
          state_r        <= RD_DAT;
        end
        RD_DAT: begin
          state_r <= DAT_WAIT;
        end
        DAT_WAIT: begin
          event_level <= avm_readdata[0];
          event_valid <= 1'b1;
          state_r     <= PUSH;
        end
        PUSH: begin
          if (event_ready) begin
            event_valid <= 1'b0;
            event_count <= sat_inc(event_count);
            if (HOLDOFF_CYCLES == 0) begin
              busy    <= 1'b0;
              state_r <= WAIT_IRQ;
            end else begin
              hold_cnt_r <= HOLD_LOAD;
              state_r    <= HOLDOFF;
            end
          end else begin
            state_r <= PUSH;
          end
        end
        HOLDOFF: begin
          if (hold_cnt_r == {HW{1'b0}}) begin
            busy    <= 1'b0;
            state_r <= WAIT_IRQ;
          end else begin
            hold_cnt_r <= hold_cnt_r - HW'(1'b1);
          end
        end
        default: begin
          busy    <= 1'b1;
          state_r <= INIT;
        end
      endcase
    end
  end

endmodule
